dct_2d_seq: RTL and testbench

DCT_2D_SEQ -- requirements
Module: dct_2d_seq

---
 rtl/dct_2d_seq.sv | 190 +++++++++++++++++++
 tb/tb_dct_2d_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_2d_seq.sv
// Sequential 8x8 2-D transform controller: row pass then column pass through an external
// pipelined 1-D engine issued LANES vectors per cycle, with a bypass mode and output hold.
module dct_2d_seq #(
    parameter int unsigned DW      = 12,
    parameter int unsigned LANES   = 2,
    parameter int unsigned ENG_LAT = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [64*DW-1:0]        in_data,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [64*DW-1:0]        out_data,
    output logic [LANES*8*DW-1:0]   eng_x,
    output logic                    eng_vld,
    input  logic [LANES*8*DW-1:0]   eng_y,
    output logic [15:0]             blk_cnt
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("dct_2d_seq: LANES must be 1, 2, 4 or 8");
    end
    if (ENG_LAT < 1 || ENG_LAT > 15) begin : g_bad_lat
        $error("dct_2d_seq: ENG_LAT must be in 1..15");
    end

    localparam int unsigned G = 8 / LANES;

    // Every phase boundary is an absolute edge number counted from the acceptance edge.
    localparam logic [5:0] E_ROW_END  = 6'(G);
    localparam logic [5:0] E_RCAP_BEG = 6'(1 + ENG_LAT);
    localparam logic [5:0] E_RCAP_END = 6'(G + ENG_LAT);
    localparam logic [5:0] E_CISS_BEG = 6'(G + ENG_LAT + 1);
    localparam logic [5:0] E_CISS_END = 6'(2 * G + ENG_LAT);
    localparam logic [5:0] E_CCAP_BEG = 6'(G + 2 * ENG_LAT + 1);
    localparam logic [5:0] E_CCAP_END = 6'(2 * G + 2 * ENG_LAT);

    typedef enum logic [2:0] {
        StIdle, StRowIssue, StRowDrain, StColIssue, StColDrain, StOutHold
    } state_t;

    state_t              r_state, w_state_nxt;
    logic   [5:0]        r_cyc;
    logic   [5:0]        w_edge;
    logic                r_mode;
    logic   [DW-1:0]     r_in  [8][8];
    logic   [DW-1:0]     r_row [8][8];
    logic   [DW-1:0]     r_col [8][8];
    logic   [LANES*8*DW-1:0] r_eng_x;
    logic                r_eng_vld;
    logic   [64*DW-1:0]  r_out;
    logic                r_out_valid;
    logic   [15:0]       r_blk_cnt;

    logic                w_acc, w_row_iss, w_row_cap, w_col_iss, w_col_cap, w_load_out, w_hs;
    logic   [2:0]        w_rig, w_rcg, w_cig, w_ccg;

    assign w_edge = r_cyc + 6'd1;
    assign w_rig  = 3'(w_edge - 6'd1);
    assign w_rcg  = 3'(w_edge - E_RCAP_BEG);
    assign w_cig  = 3'(w_edge - E_CISS_BEG);
    assign w_ccg  = 3'(w_edge - E_CCAP_BEG);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        w_row_iss   = 1'b0;
        w_col_iss   = 1'b0;
        w_load_out  = 1'b0;
        w_hs        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_acc       = 1'b1;
                    w_state_nxt = mode ? StOutHold : StRowIssue;
                end
            end
            StRowIssue: begin
                w_row_iss = 1'b1;
                if (w_edge == E_ROW_END) w_state_nxt = StRowDrain;
            end
            StRowDrain: begin
                if (w_edge == E_RCAP_END) w_state_nxt = StColIssue;
            end
            StColIssue: begin
                w_col_iss = 1'b1;
                if (w_edge == E_CISS_END) w_state_nxt = StColDrain;
            end
            StColDrain: begin
                if (w_edge == E_CCAP_END) w_state_nxt = StOutHold;
            end
            StOutHold: begin
                // First edge in this state publishes the result; later edges wait for the sink.
                if (!r_out_valid) begin
                    w_load_out = 1'b1;
                end else if (out_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        // Captures may overlap the tail of an issue phase when ENG_LAT < G.
        w_row_cap = (r_state inside {StRowIssue, StRowDrain}) &&
                    (w_edge >= E_RCAP_BEG) && (w_edge <= E_RCAP_END);
        w_col_cap = (r_state inside {StColIssue, StColDrain}) &&
                    (w_edge >= E_CCAP_BEG) && (w_edge <= E_CCAP_END);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc       <= '0;
            r_mode      <= 1'b0;
            r_eng_x     <= '0;
            r_eng_vld   <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_blk_cnt   <= '0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_in[r][c]  <= '0;
                    r_row[r][c] <= '0;
                    r_col[r][c] <= '0;
                end
            end
        end else begin
            if (w_acc) begin
                r_cyc  <= '0;
                r_mode <= mode;
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        r_in[r][c] <= in_data[(r*8+c)*DW +: DW];
                    end
                end
            end else if (r_state != StIdle) begin
                r_cyc <= w_edge;
            end

            r_eng_vld <= w_row_iss | w_col_iss;
            for (int l = 0; l < int'(LANES); l++) begin
                for (int e = 0; e < 8; e++) begin
                    if (w_row_iss) begin
                        r_eng_x[(l*8+e)*DW +: DW] <= r_in[3'(32'(w_rig) * LANES + l)][e];
                    end
                    if (w_col_iss) begin
                        r_eng_x[(l*8+e)*DW +: DW] <= r_row[e][3'(32'(w_cig) * LANES + l)];
                    end
                    if (w_row_cap) begin
                        r_row[3'(32'(w_rcg) * LANES + l)][e] <= eng_y[(l*8+e)*DW +: DW];
                    end
                    if (w_col_cap) begin
                        r_col[3'(32'(w_ccg) * LANES + l)][e] <= eng_y[(l*8+e)*DW +: DW];
                    end
                end
            end

            if (w_load_out) begin
                r_out_valid <= 1'b1;
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        r_out[(r*8+c)*DW +: DW] <= r_mode ? r_in[r][c] : r_col[c][r];
                    end
                end
            end
            if (w_hs) begin
                r_out_valid <= 1'b0;
                r_blk_cnt   <= r_blk_cnt + 16'd1;
            end
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign eng_x     = r_eng_x;
    assign eng_vld   = r_eng_vld;
    assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_dct_2d_seq.sv
// Directed bench for dct_2d_seq: LANES=2 main instance plus LANES=1 and LANES=8 instances,
// each driven through a pipelined identity (optionally element-reversing) engine stub.
module tb_dct_2d_seq;

    localparam int DW = 12;
    localparam int VW = 8 * DW;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset_n;
    logic [64*DW-1:0]  in_data;
    logic              mode;
    logic              out_ready;
    logic              rev;
    int                n_vec = 0;
    int                n_bad = 0;

    // Main instance, LANES=2
    logic              iv2, ir2, ov2, ev2;
    logic [64*DW-1:0]  od2;
    logic [2*VW-1:0]   ex2, ey2, s2a, s2b;
    logic [15:0]       bc2;

    dct_2d_seq #(.DW(DW), .LANES(2), .ENG_LAT(3)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2), .in_data(in_data),
        .mode(mode), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .eng_x(ex2),
        .eng_vld(ev2), .eng_y(ey2), .blk_cnt(bc2)
    );

    always @(posedge clock) begin
        s2a <= ex2;
        s2b <= s2a;
    end

    always_comb begin
        ey2 = s2b;
        if (rev) begin
            for (int l = 0; l < 2; l++) begin
                for (int e = 0; e < 8; e++) begin
                    ey2[(l*8+e)*DW +: DW] = s2b[(l*8+7-e)*DW +: DW];
                end
            end
        end
    end

    // LANES=1 instance
    logic              iv1, ir1, ov1, ev1;
    logic [64*DW-1:0]  od1;
    logic [VW-1:0]     ex1, s1a, s1b;
    logic [15:0]       bc1;

    dct_2d_seq #(.DW(DW), .LANES(1), .ENG_LAT(3)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
        .mode(mode), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .eng_x(ex1),
        .eng_vld(ev1), .eng_y(s1b), .blk_cnt(bc1)
    );

    always @(posedge clock) begin
        s1a <= ex1;
        s1b <= s1a;
    end

    // LANES=8 instance
    logic              iv8, ir8, ov8, ev8;
    logic [64*DW-1:0]  od8;
    logic [8*VW-1:0]   ex8, s8a, s8b;
    logic [15:0]       bc8;

    dct_2d_seq #(.DW(DW), .LANES(8), .ENG_LAT(3)) dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .in_data(in_data),
        .mode(mode), .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .eng_x(ex8),
        .eng_vld(ev8), .eng_y(s8b), .blk_cnt(bc8)
    );

    always @(posedge clock) begin
        s8a <= ex8;
        s8b <= s8a;
    end

    task automatic test_reset();
        reset_n = 1'b0;
        iv2 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
        in_data = '0; mode = 1'b0; out_ready = 1'b0; rev = 1'b0;
        #1;
        n_vec++;
        if ({ir2, ov2, ev2} !== 3'b100) begin
            n_bad++; $display("FAIL reset_flags: got %b want 100", {ir2, ov2, ev2});
        end
        n_vec++;
        if (ex2 !== '0 || od2 !== '0 || bc2 !== 16'd0) begin
            n_bad++; $display("FAIL reset_data: eng_x %h out %h cnt %h want zeros", ex2, od2, bc2);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_identity();
        logic [63:0]      vmask = '0;
        logic [2*VW-1:0]  ex_first = '0;
        logic [2*VW-1:0]  ex_last;
        logic [64*DW-1:0] held;
        int               first = -1;
        bit               hold_ok = 1'b1;
        for (int p = 0; p < 64; p++) in_data[p*DW +: DW] = DW'(p);
        for (int l = 0; l < 2; l++)
            for (int e = 0; e < 8; e++) ex_last[(l*8+e)*DW +: DW] = DW'(e*8 + 6 + l);
        mode = 1'b0; rev = 1'b0; out_ready = 1'b0;
        n_vec++;
        if (ir2 !== 1'b1) begin n_bad++; $display("FAIL first_ready: got %b want 1", ir2); end
        iv2 = 1'b1;
        @(negedge clock);
        iv2 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (ev2) vmask[n] = 1'b1;
            if (n == 1) ex_first = ex2;
            if (ov2) begin first = n; break; end
        end
        n_vec++;
        if (first != 15) begin n_bad++; $display("FAIL id_latency: got %0d want 15", first); end
        n_vec++;
        if (vmask !== 64'hF1E) begin
            n_bad++; $display("FAIL id_eng_vld: got %h want f1e", vmask);
        end
        n_vec++;
        if (ex_first !== in_data[2*VW-1:0]) begin
            n_bad++; $display("FAIL id_row_issue: got %h want %h", ex_first, in_data[2*VW-1:0]);
        end
        n_vec++;
        if (ex2 !== ex_last) begin
            n_bad++; $display("FAIL id_eng_x_hold: got %h want %h", ex2, ex_last);
        end
        n_vec++;
        if (od2 !== in_data) begin
            n_bad++; $display("FAIL id_data: got %h want %h", od2, in_data);
        end
        held = od2;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (od2 !== held || ir2 !== 1'b0 || ov2 !== 1'b1) hold_ok = 1'b0;
        end
        n_vec++;
        if (!hold_ok) begin n_bad++; $display("FAIL backpressure_hold: got 0 want 1"); end
        n_vec++;
        if (bc2 !== 16'd0) begin n_bad++; $display("FAIL cnt_pre: got %h want 0", bc2); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_vec++;
        if ({ov2, ir2, bc2} !== {2'b01, 16'd1}) begin
            n_bad++; $display("FAIL handshake: got v%b r%b cnt %h want v0 r1 cnt 1", ov2, ir2, bc2);
        end
    endtask

    task automatic test_reverse();
        logic [64*DW-1:0] exp;
        int               first = -1;
        for (int p = 0; p < 64; p++) in_data[p*DW +: DW] = DW'(p*37 + 5);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                exp[(r*8+c)*DW +: DW] = in_data[((7-r)*8 + (7-c))*DW +: DW];
        rev = 1'b1;
        iv2 = 1'b1;
        @(negedge clock);
        iv2 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (ov2) begin first = n; break; end
        end
        n_vec++;
        if (first != 15) begin n_bad++; $display("FAIL rev_latency: got %0d want 15", first); end
        n_vec++;
        if (od2 !== exp) begin n_bad++; $display("FAIL rev_data: got %h want %h", od2, exp); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        rev = 1'b0;
        n_vec++;
        if (bc2 !== 16'd2) begin n_bad++; $display("FAIL rev_cnt: got %h want 2", bc2); end
    endtask

    task automatic test_bypass();
        int first = -1;
        bit vld_seen = 1'b0;
        for (int p = 0; p < 64; p++) in_data[p*DW +: DW] = DW'(12'h800 | p);
        mode = 1'b1;
        iv2 = 1'b1;
        @(negedge clock);
        iv2 = 1'b0;
        mode = 1'b0;
        n_vec++;
        if ({ov2, ir2} !== 2'b00) begin
            n_bad++; $display("FAIL byp_edge0: got %b want 00", {ov2, ir2});
        end
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (ev2) vld_seen = 1'b1;
            if (ov2 && first < 0) first = n;
        end
        n_vec++;
        if (first != 1) begin n_bad++; $display("FAIL byp_latency: got %0d want 1", first); end
        n_vec++;
        if (od2 !== in_data) begin n_bad++; $display("FAIL byp_data: got %h want %h", od2, in_data); end
        n_vec++;
        if (vld_seen) begin n_bad++; $display("FAIL byp_eng_vld: got 1 want 0"); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_vec++;
        if (bc2 !== 16'd3) begin n_bad++; $display("FAIL byp_cnt: got %h want 3", bc2); end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        for (int p = 0; p < 64; p++) in_data[p*DW +: DW] = DW'(p*5 + 1);
        iv2 = 1'b1;
        @(negedge clock);
        iv2 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({ir2, ov2, ev2} !== 3'b100) begin
            n_bad++; $display("FAIL mid_reset_flags: got %b want 100", {ir2, ov2, ev2});
        end
        n_vec++;
        if (ex2 !== '0 || od2 !== '0 || bc2 !== 16'd0) begin
            n_bad++; $display("FAIL mid_reset_data: eng_x %h out %h cnt %h want zeros", ex2, od2, bc2);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int p = 0; p < 64; p++) in_data[p*DW +: DW] = DW'(4000 - p*11);
        iv2 = 1'b1;
        @(negedge clock);
        iv2 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (ov2) begin first = n; break; end
        end
        n_vec++;
        if (first != 15) begin n_bad++; $display("FAIL post_reset_latency: got %0d want 15", first); end
        n_vec++;
        if (od2 !== in_data) begin
            n_bad++; $display("FAIL post_reset_data: got %h want %h", od2, in_data);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_vec++;
        if (bc2 !== 16'd1) begin n_bad++; $display("FAIL post_reset_cnt: got %h want 1", bc2); end
    endtask

    task automatic test_lanes1();
        int first = -1;
        for (int p = 0; p < 64; p++) in_data[p*DW +: DW] = DW'(p*3 + 7);
        iv1 = 1'b1;
        @(negedge clock);
        iv1 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (ov1) begin first = n; break; end
        end
        n_vec++;
        if (first != 23) begin n_bad++; $display("FAIL l1_latency: got %0d want 23", first); end
        n_vec++;
        if (od1 !== in_data) begin n_bad++; $display("FAIL l1_data: got %h want %h", od1, in_data); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_vec++;
        if (bc1 !== 16'd1) begin n_bad++; $display("FAIL l1_cnt: got %h want 1", bc1); end
    endtask

    task automatic test_lanes8();
        int first = -1;
        for (int p = 0; p < 64; p++) in_data[p*DW +: DW] = DW'(2047 - p*9);
        iv8 = 1'b1;
        @(negedge clock);
        iv8 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (ov8) begin first = n; break; end
        end
        n_vec++;
        if (first != 9) begin n_bad++; $display("FAIL l8_latency: got %0d want 9", first); end
        n_vec++;
        if (od8 !== in_data) begin n_bad++; $display("FAIL l8_data: got %h want %h", od8, in_data); end
        force dut8.r_blk_cnt = 16'hFFFF;
        #1;
        release dut8.r_blk_cnt;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_vec++;
        if ({ov8, bc8} !== {1'b0, 16'd0}) begin
            n_bad++; $display("FAIL l8_wrap: got v%b cnt %h want v0 cnt 0", ov8, bc8);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_reverse();
        test_bypass();
        test_reset_mid();
        test_lanes1();
        test_lanes8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
